// File: rtl/load_store_unit.sv
// RV32I memory stage: loads/stores over a single-outstanding req/ack bus, everything else passes through.
// Optional build macro LSU_MISALIGN_TRAP_EN: trap misaligned H/W accesses and add a misalign output.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_alu,
    input  logic [31:0] in_rs2,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_wb_en,
    output logic [4:0]  out_rd,
    output logic [31:0] out_data
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic        misalign
`endif
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_ACK = 2'd1,
        S_HOLD     = 2'd2
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_wmask_q, mem_wmask_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  a_q, a_d;
    logic        out_valid_q, out_valid_d;
    logic        out_wb_en_q, out_wb_en_d;
    logic [4:0]  out_rd_q, out_rd_d;
    logic [31:0] out_data_q, out_data_d;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign_q, misalign_d;
`endif

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [1:0]  a;
    logic        is_load, is_store, is_branch, is_mem;
    logic        trap;
    logic        accept;
    logic [3:0]  st_mask;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic        unused_inst_bits;

    assign opcode    = in_inst[6:0];
    assign funct3    = in_inst[14:12];
    assign rd        = in_inst[11:7];
    assign a         = in_alu[1:0];
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_mem    = is_load | is_store;
    assign unused_inst_bits = ^in_inst[31:15];

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = is_mem & (((funct3[1:0] == 2'b01) & a[0]) |
                            ((funct3[1:0] == 2'b10) & (a != 2'b00)));
`else
    assign trap = 1'b0;
`endif

    // A consumed packet frees the stage in the same cycle, so HOLD with out_ready accepts too.
    assign in_ready = (state_q != S_WAIT_ACK) & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        st_mask  = 4'b1111;
        st_wdata = in_rs2;
        case (funct3[1:0])
            2'b00: begin
                st_mask  = 4'b0001 << a;
                st_wdata = {4{in_rs2[7:0]}};
            end
            2'b01: begin
                st_mask  = 4'b0011 << {a[1], 1'b0};
                st_wdata = {2{in_rs2[15:0]}};
            end
            default: ;
        endcase
    end

    assign ld_byte = mem_rdata[{a_q, 3'b000} +: 8];
    assign ld_half = a_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        ld_data = mem_rdata;
        case (funct3_q)
            3'b000: ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100: ld_data = {24'd0, ld_byte};
            3'b001: ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101: ld_data = {16'd0, ld_half};
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wmask_d = mem_wmask_q;
        mem_wdata_d = mem_wdata_q;
        funct3_d    = funct3_q;
        a_d         = a_q;
        out_valid_d = out_valid_q;
        out_wb_en_d = out_wb_en_q;
        out_rd_d    = out_rd_q;
        out_data_d  = out_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_d  = misalign_q;
`endif

        case (state_q)
            S_WAIT_ACK: begin
                if (mem_ack) begin
                    state_d     = S_HOLD;
                    mem_req_d   = 1'b0;
                    out_valid_d = 1'b1;
                    // Stores report their effective address; loads the extracted lane.
                    out_data_d  = mem_we_q ? {mem_addr_q[31:2], a_q} : ld_data;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: ;
        endcase

        if (accept) begin
            out_rd_d    = rd;
            out_wb_en_d = (rd != 5'd0) & ~is_store & ~is_branch & ~trap;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_d  = trap;
`endif
            if (is_mem & ~trap) begin
                state_d     = S_WAIT_ACK;
                mem_req_d   = 1'b1;
                mem_we_d    = is_store;
                mem_addr_d  = {in_alu[31:2], 2'b00};
                mem_wmask_d = is_store ? st_mask : 4'b0000;
                mem_wdata_d = is_store ? st_wdata : 32'd0;
                funct3_d    = funct3;
                a_d         = a;
                out_valid_d = 1'b0;
            end else begin
                state_d     = S_HOLD;
                out_valid_d = 1'b1;
                out_data_d  = in_alu;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wmask_q <= 4'b0000;
            mem_wdata_q <= 32'd0;
            funct3_q    <= 3'd0;
            a_q         <= 2'd0;
            out_valid_q <= 1'b0;
            out_wb_en_q <= 1'b0;
            out_rd_q    <= 5'd0;
            out_data_q  <= 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wmask_q <= mem_wmask_d;
            mem_wdata_q <= mem_wdata_d;
            funct3_q    <= funct3_d;
            a_q         <= a_d;
            out_valid_q <= out_valid_d;
            out_wb_en_q <= out_wb_en_d;
            out_rd_q    <= out_rd_d;
            out_data_q  <= out_data_d;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wmask = mem_wmask_q;
    assign mem_wdata = mem_wdata_q;
    assign out_valid = out_valid_q;
    assign out_wb_en = out_wb_en_q;
    assign out_rd    = out_rd_q;
    assign out_data  = out_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign  = misalign_q;
`endif

endmodule
